dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Sequencer and two-port arbiter in front of the word-addressed data memory.
- Arbitrates between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Converts byte-address, size and signedness requests into the memory's word address, 4-bit write-lane mask (wmem) and 5-bit read select (rmem).
- The memory zeroes unwritten bytes on a store, so the block performs read-modify-write for sub-word stores. Misaligned and out-of-range requests return an error without touching memory.

Parameters:
- ADDR_W, 15, word-address width of the data memory; valid byte addresses are 0 .. 2^(ADDR_W+2)-1.

Ports:
- clk  in  1  clock; memory samples on negedge, this block on posedge
- rst  in  1  asynchronous, active-high reset
- m0_req_valid, m1_req_valid  in  1  request valid
- m0_req_ready, m1_req_ready  out  1  request accepted this cycle
- m0_req_we, m1_req_we  in  1  1 = store, 0 = load
- m0_req_size, m1_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- m0_req_unsigned, m1_req_unsigned  in  1  zero-extend load
- m0_req_addr, m1_req_addr  in  32  byte address
- m0_req_wdata, m1_req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester index of the response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or out of range
- mem_addr  out  32  word index, zero-extended
- wmem  out  4  write-lane mask to memory
- rmem  out  5  {signed, lanes} read select to memory
- store_data  out  32  write data to memory
- load_data  in  32  lane-extracted read data from memory

Behaviour:
- Reset (async): state IDLE; rsp_valid, rsp_id, rsp_err, rsp_rdata, mem_addr, wmem, rmem and store_data all 0; last_grant = 1, so port 0 wins the first tie.
- Memory-side outputs are decoded from registered state only. wmem and rmem are nonzero only in the access states listed below.
- States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
- Arbitration (IDLE only): if both ports are valid, grant the port opposite last_grant; otherwise grant the valid one.
  - m*_req_ready is combinational: high only in IDLE, for the granted port.
  - On valid&&ready, latch the request and update last_grant.
- Requesters must hold inputs stable while valid && !ready.
- Lanes:
  - byte: 1 << addr[1:0]
  - half: 0011 if addr[1] = 0, else 1100
  - word: 1111
- Error checks, evaluated at acceptance:
  - size = 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr[31:ADDR_W+2] != 0
  - Any of these goes IDLE -> RESP with rsp_err = 1 and rsp_rdata = 0; no memory access.
- LOAD (1 cycle):
  - mem_addr = addr[ADDR_W+1:2]; rmem = {~unsigned, lanes}, except a word load drives 01111.
  - Capture load_data into rsp_rdata at the closing posedge -> RESP.
- WRITE (word store, 1 cycle): mem_addr driven, wmem = 1111, store_data = wdata -> RESP.
- RMW_RD (sub-word store, 1 cycle): rmem = 01111; capture the raw word at the posedge -> RMW_WR.
- RMW_WR (1 cycle):
  - wmem = 1111; store_data = raw word with the target lanes replaced by wdata[7:0] or wdata[15:0].
  - Replicate the byte or half into the selected lanes -> RESP.
- Latency from the acceptance edge to rsp_valid high:
  - error: 0 cycles (valid right after acceptance)
  - load or word store: 1 cycle
  - sub-word store: 2 cycles
- RESP:
  - rsp_valid = 1; rsp_id, rsp_err and rsp_rdata held stable until rsp_valid && rsp_ready -> IDLE.
  - No acceptance while in RESP, so the earliest next grant is the cycle after the handshake.
- Reset mid-operation: wmem and rmem drop to 0 immediately. If reset asserts during RMW_WR before the negedge, memory is unchanged. Any pending response is discarded.

Test Plan:
1. Word store then load: m0 sw addr 0x10, wdata 0xDEADBEEF -> mem_addr = 4, wmem = 1111 for one cycle, rsp_valid 1 cycle after acceptance. Then lw 0x10 -> rmem = 01111, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
2. Byte RMW: word at 0x20 = 0x11223344; m0 sb addr 0x22, wdata 0x000000AB -> RMW_RD with rmem = 01111, then RMW_WR with wmem = 1111 and store_data = 0x11AB3344. Then lb 0x22 -> 0xFFFFFFAB; lbu 0x22 -> 0x000000AB.
3. Half RMW and loads: sh addr 0x22, wdata 0x8001 onto word 0x11AB3344 -> word becomes 0x80013344. Then lh 0x22 -> 0xFFFF8001; lhu 0x22 -> 0x00008001.
4. Errors:
   - lw 0x21 -> rsp_err = 1, rsp_rdata = 0.
   - size 11 -> rsp_err = 1.
   - addr 0x00020000 with ADDR_W = 15 -> rsp_err = 1.
   - wmem and rmem remain 0 throughout all three.
5. Arbitration and backpressure:
   - Both ports issue continuous loads -> grants go 0,1,0,1 and rsp_id matches each grant.
   - Hold rsp_ready low for 3 cycles -> RESP outputs stable, both m*_req_ready low.
6. Reset during RMW_WR: assert rst mid-cycle before the negedge -> wmem = 0 immediately, memory word unchanged, state IDLE, all outputs 0.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: requester, response and memory-side signals of the data-memory controller
interface dmem_if;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_req_unsigned;
    logic [1:0]  m0_req_size;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_req_unsigned;
    logic [1:0]  m1_req_size;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, store_data, load_data;
    logic [3:0]  wmem;
    logic [4:0]  rmem;
    modport slave (
        input  m0_req_valid, m0_req_we, m0_req_size, m0_req_unsigned, m0_req_addr, m0_req_wdata,
        input  m1_req_valid, m1_req_we, m1_req_size, m1_req_unsigned, m1_req_addr, m1_req_wdata,
        input  rsp_ready, load_data,
        output m0_req_ready, m1_req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
        output mem_addr, wmem, rmem, store_data
    );
    modport master (
        output m0_req_valid, m0_req_we, m0_req_size, m0_req_unsigned, m0_req_addr, m0_req_wdata,
        output m1_req_valid, m1_req_we, m1_req_size, m1_req_unsigned, m1_req_addr, m1_req_wdata,
        output rsp_ready, load_data,
        input  m0_req_ready, m1_req_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata,
        input  mem_addr, wmem, rmem, store_data
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port arbiter and load/store sequencer (with sub-word read-modify-write) for a word memory
module dmem_ctrl #(
    parameter int ADDR_W = 15
) (
    input logic clk,
    input logic rst,
    dmem_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} state_t;
    state_t state;
    logic last_grant, gnt, take, err, sel_we, sel_unsigned;
    logic [1:0] sel_size;
    logic [3:0] lanes, lanes_q;
    logic [31:0] sel_addr, sel_wdata, rep, rep_q, lane_mask, merged;
    always_comb begin
        gnt = (bus.m0_req_valid && bus.m1_req_valid) ? ~last_grant : bus.m1_req_valid;
        take = state == IDLE && (bus.m0_req_valid || bus.m1_req_valid);
        sel_we = gnt ? bus.m1_req_we : bus.m0_req_we;
        sel_unsigned = gnt ? bus.m1_req_unsigned : bus.m0_req_unsigned;
        sel_size = gnt ? bus.m1_req_size : bus.m0_req_size;
        sel_addr = gnt ? bus.m1_req_addr : bus.m0_req_addr;
        sel_wdata = gnt ? bus.m1_req_wdata : bus.m0_req_wdata;
        lanes = sel_size == 2'b00 ? 4'b0001 << sel_addr[1:0] :
                sel_size == 2'b01 ? (sel_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        err = sel_size == 2'b11 || (sel_size == 2'b01 && sel_addr[0]) ||
              (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) || sel_addr[31:ADDR_W+2] != '0;
        // Replicating the store datum lets the merge use a plain lane mask
        rep = sel_size == 2'b00 ? {4{sel_wdata[7:0]}} :
              sel_size == 2'b01 ? {2{sel_wdata[15:0]}} : sel_wdata;
        lane_mask = {{8{lanes_q[3]}}, {8{lanes_q[2]}}, {8{lanes_q[1]}}, {8{lanes_q[0]}}};
        merged = (bus.load_data & ~lane_mask) | (rep_q & lane_mask);
    end
    assign bus.m0_req_ready = take && !gnt;
    assign bus.m1_req_ready = take && gnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            lanes_q <= '0;
            rep_q <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= 1'b0;
            bus.rsp_err <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.mem_addr <= '0;
            bus.wmem <= '0;
            bus.rmem <= '0;
            bus.store_data <= '0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    last_grant <= gnt;
                    bus.rsp_id <= gnt;
                    bus.rsp_err <= err;
                    bus.rsp_rdata <= '0;
                    lanes_q <= lanes;
                    rep_q <= rep;
                    bus.mem_addr <= 32'(sel_addr[ADDR_W+1:2]);
                    if (err) begin
                        state <= RESP;
                        bus.rsp_valid <= 1'b1;
                    end else if (!sel_we) begin
                        state <= LOAD;
                        bus.rmem <= sel_size == 2'b10 ? 5'b01111 : {~sel_unsigned, lanes};
                    end else if (sel_size == 2'b10) begin
                        state <= WRITE;
                        bus.wmem <= 4'b1111;
                        bus.store_data <= rep;
                    end else begin
                        state <= RMW_RD;
                        bus.rmem <= 5'b01111;
                    end
                end
                LOAD: begin
                    state <= RESP;
                    bus.rmem <= '0;
                    bus.rsp_rdata <= bus.load_data;
                    bus.rsp_valid <= 1'b1;
                end
                RMW_RD: begin
                    state <= RMW_WR;
                    bus.rmem <= '0;
                    bus.wmem <= 4'b1111;
                    bus.store_data <= merged;
                end
                WRITE, RMW_WR: begin
                    state <= RESP;
                    bus.wmem <= '0;
                    bus.rsp_valid <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    state <= IDLE;
                    bus.rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed tests with a byte-level reference model and a per-cycle compare process
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    dmem_if bus();
    dmem_ctrl #(.ADDR_W(15)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        bit id; bit err; logic [31:0] rdata; int lat; bit we; int a; int n; logic [31:0] wd;
    } exp_t;
    exp_t q[$];
    bit grants[$];
    logic [7:0] ref_b [int];
    logic [31:0] mem [0:1023];
    int vectors = 0, miscompares = 0, cyc = 0, acc_cyc = 0, rsp_count = 0, wr_cnt = 0, rd_cnt = 0;
    int last_lat = -1;
    logic [31:0] last_rdata, last_waddr, last_sd, prev_rdata;
    logic [3:0] last_wmem;
    logic [4:0] last_rmem;
    bit last_err, last_id, prev_v, prev_r, prev_id, prev_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rbyte(input int a);
        return ref_b.exists(a) ? ref_b[a] : 8'h00;
    endfunction

    // Reference: byte-addressed memory, alignment by modulo, range by magnitude
    function automatic exp_t predict(input bit id, input bit we, input bit uns, input logic [1:0] sz,
                                     input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n = 1 << sz;
        e.id = id; e.we = we; e.a = int'(a); e.n = n; e.wd = wd; e.rdata = 32'h0;
        e.err = sz == 2'd3 || (a % n) != 0 || a >= 32'h20000;
        e.lat = e.err ? 0 : (we && n < 4) ? 2 : 1;
        if (!e.err && !we) begin
            for (int i = 0; i < n; i++) e.rdata |= 32'(rbyte(e.a + i)) << (8 * i);
            if (!uns && n < 4 && e.rdata[8 * n - 1]) e.rdata |= 32'hFFFFFFFF << (8 * n);
        end
        return e;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] w, input logic [4:0] r);
        logic [31:0] v;
        int nb = 4;
        v = w;
        case (r[3:0])
            4'b0001: begin v = {24'h0, w[7:0]}; nb = 1; end
            4'b0010: begin v = {24'h0, w[15:8]}; nb = 1; end
            4'b0100: begin v = {24'h0, w[23:16]}; nb = 1; end
            4'b1000: begin v = {24'h0, w[31:24]}; nb = 1; end
            4'b0011: begin v = {16'h0, w[15:0]}; nb = 2; end
            4'b1100: begin v = {16'h0, w[31:16]}; nb = 2; end
            default: v = w;
        endcase
        if (r[4] && nb == 1 && v[7]) v |= 32'hFFFFFF00;
        if (r[4] && nb == 2 && v[15]) v |= 32'hFFFF0000;
        return v;
    endfunction

    // Memory device: samples on the falling edge, zeroes unwritten lanes on a store
    always @(negedge clk) begin
        if (bus.wmem != 4'b0)
            mem[bus.mem_addr[9:0]] <= bus.store_data & {{8{bus.wmem[3]}}, {8{bus.wmem[2]}}, {8{bus.wmem[1]}}, {8{bus.wmem[0]}}};
        bus.load_data <= dev_rd(mem[bus.mem_addr[9:0]], bus.rmem);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            check("ready_onehot", 32'(bus.m0_req_ready && bus.m1_req_ready), 32'h0);
            if (bus.rsp_valid) begin
                check("quiet_in_resp", 32'({bus.wmem, bus.rmem, bus.m0_req_ready, bus.m1_req_ready}), 32'h0);
                if (!prev_v && q.size() > 0) begin
                    last_lat = cyc - acc_cyc - 1;
                    check("latency", 32'(last_lat), 32'(q[0].lat));
                end else if (prev_v && !prev_r) begin
                    check("hold_id", 32'(bus.rsp_id), 32'(prev_id));
                    check("hold_err", 32'(bus.rsp_err), 32'(prev_err));
                    check("hold_rdata", bus.rsp_rdata, prev_rdata);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                last_rdata = bus.rsp_rdata; last_err = bus.rsp_err; last_id = bus.rsp_id;
                check("rsp_outstanding", 32'(q.size()), 32'h1);
                if (q.size() > 0) begin
                    check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                    check("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
                    check("rsp_rdata", bus.rsp_rdata, q[0].rdata);
                    if (q[0].we && !q[0].err)
                        for (int i = 0; i < q[0].n; i++) ref_b[q[0].a + i] = 8'(q[0].wd >> (8 * i));
                    void'(q.pop_front());
                end
            end
            if (bus.m0_req_valid && bus.m0_req_ready) begin
                q.push_back(predict(1'b0, bus.m0_req_we, bus.m0_req_unsigned, bus.m0_req_size, bus.m0_req_addr, bus.m0_req_wdata));
                grants.push_back(1'b0); acc_cyc = cyc;
            end
            if (bus.m1_req_valid && bus.m1_req_ready) begin
                q.push_back(predict(1'b1, bus.m1_req_we, bus.m1_req_unsigned, bus.m1_req_size, bus.m1_req_addr, bus.m1_req_wdata));
                grants.push_back(1'b1); acc_cyc = cyc;
            end
            if (bus.wmem != 4'b0) begin
                wr_cnt++; last_wmem = bus.wmem; last_waddr = bus.mem_addr; last_sd = bus.store_data;
            end
            if (bus.rmem != 5'b0) begin
                rd_cnt++; last_rmem = bus.rmem;
            end
            prev_v = bus.rsp_valid; prev_r = bus.rsp_ready;
            prev_id = bus.rsp_id; prev_err = bus.rsp_err; prev_rdata = bus.rsp_rdata;
        end
    end

    task automatic drive(input bit p, input bit v, input bit we, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            bus.m1_req_valid = v; bus.m1_req_we = we; bus.m1_req_size = sz;
            bus.m1_req_unsigned = u; bus.m1_req_addr = a; bus.m1_req_wdata = wd;
        end else begin
            bus.m0_req_valid = v; bus.m0_req_we = we; bus.m0_req_size = sz;
            bus.m0_req_unsigned = u; bus.m0_req_addr = a; bus.m0_req_wdata = wd;
        end
    endtask

    task automatic wait_accept(input bit p);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = p ? bus.m1_req_ready : bus.m0_req_ready;
        end
        check("accept", 32'(ok), 32'h1);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 30 && rsp_count < n; i++) @(posedge clk);
        check("rsp_arrived", 32'(rsp_count >= n), 32'h1);
        #1;
    endtask

    task automatic op(input bit p, input bit we, input logic [1:0] sz, input bit u,
                      input logic [31:0] a, input logic [31:0] wd);
        int base = rsp_count;
        drive(p, 1'b1, we, sz, u, a, wd);
        wait_accept(p);
        @(posedge clk); #1;
        drive(p, 1'b0, we, sz, u, a, wd);
        wait_rsp(base + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required to finish", $time);
        $fatal(1);
    end

    initial begin
        int base, acc;
        bit found;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.load_data = 32'h0;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        #2;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset_rsp", 32'({bus.rsp_id, bus.rsp_err}), 32'h0);
        check("reset_rdata", bus.rsp_rdata, 32'h0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        check("reset_strobes", 32'({bus.wmem, bus.rmem}), 32'h0);
        check("reset_store_data", bus.store_data, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Word store then load
        base = wr_cnt;
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_writes", 32'(wr_cnt - base), 32'h1);
        check("sw_mem_addr", last_waddr, 32'h4);
        check("sw_wmem", 32'(last_wmem), 32'hF);
        check("sw_store_data", last_sd, 32'hDEADBEEF);
        check("sw_latency", 32'(last_lat), 32'h1);
        op(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw_rmem", 32'(last_rmem), 32'h0F);
        check("lw_rdata", last_rdata, 32'hDEADBEEF);
        check("lw_err", 32'(last_err), 32'h0);

        // Byte read-modify-write
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
        op(1'b0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB);
        check("sb_rmem", 32'(last_rmem), 32'h0F);
        check("sb_wmem", 32'(last_wmem), 32'hF);
        check("sb_mem_addr", last_waddr, 32'h8);
        check("sb_store_data", last_sd, 32'h11AB3344);
        check("sb_latency", 32'(last_lat), 32'h2);
        op(1'b0, 1'b0, 2'd0, 1'b0, 32'h22, 32'h0);
        check("lb_rdata", last_rdata, 32'hFFFFFFAB);
        check("lb_rmem", 32'(last_rmem), 32'h14);
        op(1'b0, 1'b0, 2'd0, 1'b1, 32'h22, 32'h0);
        check("lbu_rdata", last_rdata, 32'h000000AB);

        // Half read-modify-write
        op(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001);
        check("sh_store_data", last_sd, 32'h80013344);
        op(1'b0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        check("lh_rdata", last_rdata, 32'hFFFF8001);
        op(1'b0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        check("lhu_rdata", last_rdata, 32'h00008001);

        // Errors never reach memory
        acc = wr_cnt + rd_cnt;
        op(1'b0, 1'b0, 2'd2, 1'b0, 32'h21, 32'h0);
        check("lw_misaligned_err", 32'(last_err), 32'h1);
        check("lw_misaligned_rdata", last_rdata, 32'h0);
        check("err_latency", 32'(last_lat), 32'h0);
        op(1'b0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        check("size11_err", 32'(last_err), 32'h1);
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h00020000, 32'h12345678);
        check("range_err", 32'(last_err), 32'h1);
        check("err_no_access", 32'(wr_cnt + rd_cnt), 32'(acc));

        // Fair arbitration from reset, both ports streaming loads
        rst = 1'b1; #2;
        @(posedge clk); #1 rst = 1'b0;
        grants.delete();
        base = rsp_count;
        drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        for (int i = 0; i < 60 && grants.size() < 4; i++) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        wait_rsp(base + 4);
        check("grant_count", 32'(grants.size()), 32'h4);
        for (int i = 0; i < 4 && i < grants.size(); i++) check("grant_order", 32'(grants[i]), 32'(i % 2));

        // Response backpressure
        base = rsp_count;
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        wait_accept(1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.rsp_valid), 32'h1);
            check("stall_ready", 32'({bus.m0_req_ready, bus.m1_req_ready}), 32'h0);
            check("stall_rdata", bus.rsp_rdata, 32'h80013344);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_accept(1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        wait_rsp(base + 2);
        check("lbu_after_stall", last_rdata, 32'h000000EF);

        // Reset while the merged word is on the bus
        drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h20, 32'h000000CD);
        wait_accept(1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h20, 32'h000000CD);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk); #1;
            found = bus.wmem != 4'b0;
        end
        check("rmw_wr_reached", 32'(found), 32'h1);
        rst = 1'b1; #1;
        check("rst_wmem", 32'({bus.wmem, bus.rmem}), 32'h0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_id, bus.rsp_err}), 32'h0);
        check("rst_outputs", bus.mem_addr | bus.store_data | bus.rsp_rdata, 32'h0);
        @(negedge clk); @(posedge clk); #1 rst = 1'b0;
        check("rst_mem_unchanged", mem[8], 32'h80013344);
        op(1'b0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check("lw_after_rst", last_rdata, 32'h80013344);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
